physical_regfile: RTL

//  Physical register file with two write ports and four read ports, plus a per-register ready bit.

---
 rtl/physical_regfile_if.sv | 41 ++++
 rtl/physical_regfile.sv | 98 +++++++++
 2 files changed

// File: rtl/physical_regfile_if.sv
// Bundle of the physical register file's write, read and allocation ports.
// Master is the pipeline side (writeback, issue, rename); slave is the register file.
interface physical_regfile_if #(
    parameter int unsigned REG_ADDR_WIDTH = 6,
    parameter int unsigned REG_DATA_WIDTH = 64
);
    // Two write ports fed by the writeback arbiter
    logic                      wr_first_valid;
    logic [REG_ADDR_WIDTH-1:0] wr_first_address;
    logic [REG_DATA_WIDTH-1:0] wr_first_data;
    logic                      wr_second_valid;
    logic [REG_ADDR_WIDTH-1:0] wr_second_address;
    logic [REG_DATA_WIDTH-1:0] wr_second_data;

    // Four read ports; index N is read port N
    logic [3:0]                rd_valid;
    logic [REG_ADDR_WIDTH-1:0] rd_address    [4];
    logic [REG_DATA_WIDTH-1:0] rd_data       [4];
    logic [3:0]                rd_ready;
    logic [3:0]                rd_data_valid;

    // Two rename allocation ports; index M is alloc port M
    logic [1:0]                alloc_valid;
    logic [REG_ADDR_WIDTH-1:0] alloc_address [2];

    modport master (
        output wr_first_valid, wr_first_address, wr_first_data,
        output wr_second_valid, wr_second_address, wr_second_data,
        output rd_valid, rd_address,
        output alloc_valid, alloc_address,
        input  rd_data, rd_ready, rd_data_valid
    );

    modport slave (
        input  wr_first_valid, wr_first_address, wr_first_data,
        input  wr_second_valid, wr_second_address, wr_second_data,
        input  rd_valid, rd_address,
        input  alloc_valid, alloc_address,
        output rd_data, rd_ready, rd_data_valid
    );
endinterface

// File: rtl/physical_regfile.sv
// Physical register file: 2 write ports, 4 registered read ports, per-register ready bits.
// Register 0 is hardwired to data 0 / ready 1.
// Optional feature: define PRF_BYPASS_EN to forward same-cycle write data (and readiness)
// into reads; otherwise reads return the pre-edge array contents.
module physical_regfile #(
    parameter int unsigned REG_ADDR_WIDTH = 6,
    parameter int unsigned REG_DATA_WIDTH = 64
) (
    input logic                clk,
    input logic                rstn,
    physical_regfile_if.slave  bus
);
    localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;
    localparam int unsigned NumRd   = 4;

    typedef logic [REG_DATA_WIDTH-1:0] data_t;

    data_t              mem_q [NumRegs];
    data_t              mem_d [NumRegs];
    logic [NumRegs-1:0] ready_q, ready_d;

    data_t              rd_data_q [NumRd];
    data_t              rd_data_d [NumRd];
    logic [NumRd-1:0]   rd_ready_q, rd_ready_d;
    logic [NumRd-1:0]   rd_data_valid_q, rd_data_valid_d;

    // Array update: writes set ready, allocations clear it afterwards so alloc wins
    always_comb begin
        mem_d   = mem_q;
        ready_d = ready_q;
        if (bus.wr_first_valid && bus.wr_first_address != '0) begin
            mem_d[bus.wr_first_address]   = bus.wr_first_data;
            ready_d[bus.wr_first_address] = 1'b1;
        end
        // Second port applied last so it wins on an address collision
        if (bus.wr_second_valid && bus.wr_second_address != '0) begin
            mem_d[bus.wr_second_address]   = bus.wr_second_data;
            ready_d[bus.wr_second_address] = 1'b1;
        end
        for (int m = 0; m < 2; m++) begin
            if (bus.alloc_valid[m] && bus.alloc_address[m] != '0) begin
                ready_d[bus.alloc_address[m]] = 1'b0;
            end
        end
    end

    // Read ports: sample pre-edge state, optionally forwarding same-cycle writes
    always_comb begin
        rd_data_d       = rd_data_q;
        rd_ready_d      = rd_ready_q;
        rd_data_valid_d = bus.rd_valid;
        for (int n = 0; n < NumRd; n++) begin
            if (bus.rd_valid[n]) begin
                // Entry 0 is never written, so it always yields 0 / ready
                rd_data_d[n]  = mem_q[bus.rd_address[n]];
                rd_ready_d[n] = ready_q[bus.rd_address[n]];
`ifdef PRF_BYPASS_EN
                if (bus.rd_address[n] != '0) begin
                    if (bus.wr_second_valid && bus.wr_second_address == bus.rd_address[n]) begin
                        rd_data_d[n]  = bus.wr_second_data;
                        rd_ready_d[n] = 1'b1;
                    end else if (bus.wr_first_valid &&
                                 bus.wr_first_address == bus.rd_address[n]) begin
                        rd_data_d[n]  = bus.wr_first_data;
                        rd_ready_d[n] = 1'b1;
                    end
                end
`endif
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
            ready_q <= '1;
            for (int n = 0; n < NumRd; n++) begin
                rd_data_q[n] <= '0;
            end
            rd_ready_q      <= '0;
            rd_data_valid_q <= '0;
        end else begin
            mem_q           <= mem_d;
            ready_q         <= ready_d;
            rd_data_q       <= rd_data_d;
            rd_ready_q      <= rd_ready_d;
            rd_data_valid_q <= rd_data_valid_d;
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.rd_ready      = rd_ready_q;
    assign bus.rd_data_valid = rd_data_valid_q;

endmodule
